// File: rtl/pacman_input_ctrl.sv
// Direction-key conditioning for Pac-Man: synchronize, debounce, latch the
// latest heading, and emit one movement strobe per step period.
module pacman_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned STEP_DIV        = 500000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_key_up,
   input  logic       i_key_down,
   input  logic       i_key_left,
   input  logic       i_key_right,
   input  logic       i_enable,
   output logic       o_up,
   output logic       o_down,
   output logic       o_left,
   output logic       o_right,
   output logic [1:0] o_dir,
   output logic       o_dir_valid
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned ST_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   // Key vectors are indexed by heading code: 0 up, 1 down, 2 left, 3 right.
   logic [3:0]      raw_n;
   logic [3:0]      sync1_n, sync2_n;
   logic [3:0]      synced;
   logic [3:0]      stable;
   logic [3:0]      press_evt;
   logic [3:0]      press_q;
   logic [DB_W-1:0] db_cnt [4];

   dir_t            dir_q, dir_nxt;
   logic            dir_valid_q;
   logic [ST_W-1:0] step_cnt;
   logic            tick;
   logic [3:0]      strobe_q;

   assign raw_n  = {i_key_right, i_key_left, i_key_down, i_key_up};
   assign synced = ~sync2_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_n <= '1;
         sync2_n <= '1;
      end else begin
         sync1_n <= raw_n;
         sync2_n <= sync1_n;
      end
   end

   always_comb begin
      press_evt = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         press_evt[k] = synced[k] && !stable[k] && (db_cnt[k] == DB_LAST);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stable  <= '0;
         press_q <= '0;
         for (int unsigned k = 0; k < 4; k++) begin
            db_cnt[k] <= '0;
         end
      end else begin
         press_q <= press_evt;
         for (int unsigned k = 0; k < 4; k++) begin
            if (synced[k] == stable[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               stable[k] <= synced[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + 1'b1;
            end
         end
      end
   end

   // Later assignments win, so up has the highest priority.
   always_comb begin
      dir_nxt = dir_q;
      if (press_q[3]) dir_nxt = DIR_RIGHT;
      if (press_q[2]) dir_nxt = DIR_LEFT;
      if (press_q[1]) dir_nxt = DIR_DOWN;
      if (press_q[0]) dir_nxt = DIR_UP;
   end

   assign tick = i_enable && (step_cnt == ST_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dir_q       <= DIR_UP;
         dir_valid_q <= 1'b0;
         step_cnt    <= '0;
         strobe_q    <= '0;
      end else begin
         dir_q <= dir_nxt;
         if (|press_q) dir_valid_q <= 1'b1;
         if (i_enable) step_cnt <= tick ? '0 : step_cnt + 1'b1;
         // Strobe decodes the heading held before this edge's update.
         strobe_q <= (tick && dir_valid_q) ? (4'b0001 << dir_q) : 4'b0000;
      end
   end

   assign o_up        = strobe_q[0];
   assign o_down      = strobe_q[1];
   assign o_left      = strobe_q[2];
   assign o_right     = strobe_q[3];
   assign o_dir       = dir_q;
   assign o_dir_valid = dir_valid_q;

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Directed bench for pacman_input_ctrl: a cycle-level reference model built
// from sample windows and enabled-edge counts, plus literal timing checks.
module tb_pacman_input_ctrl;

   localparam int D = 4;
   localparam int S = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic key_up = 1'b1, key_down = 1'b1, key_left = 1'b1, key_right = 1'b1;
   logic enable = 1'b1;
   logic o_up, o_down, o_left, o_right, o_dir_valid;
   logic [1:0] o_dir;

   int checks = 0;
   int failures = 0;

   pacman_input_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_DIV(S)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_key_up(key_up), .i_key_down(key_down),
      .i_key_left(key_left), .i_key_right(key_right),
      .i_enable(enable),
      .o_up(o_up), .o_down(o_down), .o_left(o_left), .o_right(o_right),
      .o_dir(o_dir), .o_dir_valid(o_dir_valid)
   );

   always #5 clk = ~clk;

   // Reference model: a key flips its accepted state once the last D
   // synchronized samples (raw delayed two edges) all disagree with it.
   logic [D+1:0] m_hist [4];
   logic [3:0]   m_stable, m_pend, m_raw, m_strb;
   logic [1:0]   m_dir;
   logic         m_valid, m_tick, m_diff;
   int           m_en;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) m_hist[k] = '0;
         m_stable = '0; m_pend = '0; m_strb = '0;
         m_dir = 2'b00; m_valid = 1'b0; m_en = 0;
      end else begin
         m_raw = ~{key_right, key_left, key_down, key_up};
         m_tick = 1'b0;
         if (enable) begin
            m_en++;
            m_tick = (m_en % S == 0);
         end
         m_strb = (m_tick && m_valid) ? (4'b0001 << m_dir) : 4'b0000;
         for (int k = 3; k >= 0; k--) begin
            if (m_pend[k]) begin
               m_dir = 2'(k);
               m_valid = 1'b1;
            end
         end
         for (int k = 0; k < 4; k++) begin
            m_hist[k] = {m_hist[k][D:0], m_raw[k]};
            m_diff = 1'b1;
            for (int j = 2; j < D + 2; j++) begin
               if (m_hist[k][j] == m_stable[k]) m_diff = 1'b0;
            end
            m_pend[k] = 1'b0;
            if (m_diff) begin
               m_stable[k] = ~m_stable[k];
               m_pend[k] = m_stable[k];
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      checks++;
      if ({o_right, o_left, o_down, o_up, o_dir, o_dir_valid} !== {m_strb, m_dir, m_valid}) begin
         failures++;
         $display("FAIL model_cmp t=%0t got strb=%b dir=%b valid=%b exp strb=%b dir=%b valid=%b",
                  $time, {o_right, o_left, o_down, o_up}, o_dir, o_dir_valid, m_strb, m_dir, m_valid);
      end
   end

   int cyc = 0;
   int last_strobe = -1;
   int last_gap = 0;
   int strobe_cnt = 0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (o_up | o_down | o_left | o_right) begin
         if (last_strobe >= 0) last_gap = cyc - last_strobe;
         last_strobe = cyc;
         strobe_cnt++;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_strobe(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk); #2; n++;
      end while (!(o_up | o_down | o_left | o_right) && n < 40);
      check(name, int'(o_up | o_down | o_left | o_right), 1);
   endtask

   initial begin
      int snap;
      #1 rst_n = 1'b0;
      #1 check("reset_async_dir", int'(o_dir), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: idle after reset
      clocks(50);
      check("idle_valid", int'(o_dir_valid), 0);
      check("idle_dir", int'(o_dir), 0);
      check("idle_strobes", strobe_cnt, 0);

      // 2: left press latency and steady strobing
      @(negedge clk) key_left = 1'b0;
      clocks(6);
      check("left_latency_e5_valid", int'(o_dir_valid), 0);
      clocks(1);
      check("left_latency_e6_valid", int'(o_dir_valid), 1);
      check("left_latency_e6_dir", int'(o_dir), 2);
      clocks(32);
      @(negedge clk) key_left = 1'b1;
      check("left_gap", last_gap, 10);

      // 3: bounces shorter than the debounce window are ignored
      repeat (5) begin
         @(negedge clk) key_down = 1'b0;
         repeat (3) @(negedge clk);
         key_down = 1'b1;
         repeat (3) @(negedge clk);
      end
      clocks(10);
      check("bounce_dir", int'(o_dir), 2);
      check("bounce_valid", int'(o_dir_valid), 1);

      // 4: simultaneous up+right, then a later right
      @(negedge clk) begin key_up = 1'b0; key_right = 1'b0; end
      clocks(10);
      check("prio_dir", int'(o_dir), 0);
      @(negedge clk) begin key_up = 1'b1; key_right = 1'b1; end
      clocks(25);
      check("up_hold_dir", int'(o_dir), 0);
      check("up_gap", last_gap, 10);
      @(negedge clk) key_right = 1'b0;
      clocks(8);
      @(negedge clk) key_right = 1'b1;
      check("right_dir", int'(o_dir), 3);
      wait_strobe("right_strobe_seen");
      check("right_is_right", int'(o_right), 1);
      check("right_phase_gap", last_gap, 10);

      // 5: pause stretches the spacing
      @(negedge clk) key_left = 1'b0;
      clocks(8);
      @(negedge clk) key_left = 1'b1;
      clocks(12);
      wait_strobe("pause_pre_strobe");
      clocks(3);
      @(negedge clk) enable = 1'b0;
      repeat (7) @(negedge clk);
      enable = 1'b1;
      wait_strobe("pause_post_strobe");
      check("pause_is_left", int'(o_left), 1);
      check("pause_gap", last_gap, 17);

      // 6: asynchronous reset in the middle of a right strobe
      @(negedge clk) key_right = 1'b0;
      clocks(8);
      @(negedge clk) key_right = 1'b1;
      clocks(1);
      wait_strobe("rst_pre_strobe");
      check("rst_pre_is_right", int'(o_right), 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_right", int'(o_right), 0);
      check("rst_async_dir", int'(o_dir), 0);
      check("rst_async_valid", int'(o_dir_valid), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      snap = strobe_cnt;
      clocks(30);
      check("post_rst_no_strobe", strobe_cnt - snap, 0);
      check("post_rst_valid", int'(o_dir_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pacman_input_ctrl.md
# pacman_input_ctrl

Conditions the four raw direction push-buttons and produces the per-step movement strobes consumed by the Pac-Man position stage. That stage moves one pixel per clock for as long as a direction input is high. This block synchronizes and debounces the keys and latches the most recent heading. It then emits exactly one single-cycle strobe per step period, so Pac-Man keeps moving in the last pressed direction at a fixed, clock-independent speed.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable clocks required to accept a key change (1 ms at 50 MHz); minimum 2.
- STEP_DIV, 500000, clocks per movement step (100 steps/s at 50 MHz); minimum 2.

Ports:
- i_clk  input  1  system clock; all logic rises on its positive edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_key_up  input  1  raw up button, active-low, asynchronous to i_clk.
- i_key_down  input  1  raw down button, active-low, asynchronous.
- i_key_left  input  1  raw left button, active-low, asynchronous.
- i_key_right  input  1  raw right button, active-low, asynchronous.
- i_enable  input  1  high = step timer runs; low = movement paused.
- o_up  output  1  one-clock step strobe, heading up.
- o_down  output  1  one-clock step strobe, heading down.
- o_left  output  1  one-clock step strobe, heading left.
- o_right  output  1  one-clock step strobe, heading right.
- o_dir  output  2  latched heading: 00 up, 01 down, 10 left, 11 right.
- o_dir_valid  output  1  high once any key press has been accepted.

## Operation
- Synchronizer: each key passes through a 2-flop synchronizer. The internal pressed level is the inverted synchronized value.
- Debounce, per key, independent:
  - Each key has a stable register (reset = released) and a counter sized to ceil(log2(DEBOUNCE_CYCLES)).
  - When the synced value equals the stable value, the counter is cleared.
  - When they differ, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, stable takes the synced value and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES clocks is discarded.
- Press event: a press is accepted on the clock where stable goes released→pressed. Release events are ignored.
- Heading register:
  - On an accepted press, o_dir takes that key's code and o_dir_valid is set.
  - o_dir_valid is cleared only by reset.
  - If several presses are accepted on the same clock, priority is up > down > left > right.
  - The heading persists after release and is replaced only by a later accepted press.
  - A key that is already held does not re-trigger.
- Step timer:
  - Counter runs 0..STEP_DIV-1 and advances only while i_enable=1.
  - On the clock where it reaches STEP_DIV-1 it wraps to 0 and raises a tick.
  - A heading change does not restart the timer.
  - While i_enable=0 the counter holds its value and no ticks occur. Heading updates still occur.
- Strobes:
  - On a tick with o_dir_valid=1, the single output matching the current o_dir is high for exactly one clock.
  - At most one of o_up/o_down/o_left/o_right is ever high.
  - Before the first accepted press, all strobes stay low.
  - If a press is accepted on the same clock as a tick, that strobe uses the old heading.

## Timing
- All outputs are registered.
- Reset values: o_up=o_down=o_left=o_right=0, o_dir=00, o_dir_valid=0. All counters are 0 and all stable registers are released.
- Reset acts asynchronously and immediately, including in the middle of a strobe or a debounce count.
- Press latency: when a raw key falls and stays low, o_dir/o_dir_valid update exactly 2+DEBOUNCE_CYCLES clocks after the first rising i_clk edge that samples it low.
- Strobe timing:
  - A strobe appears on the clock after the timer holds STEP_DIV-1.
  - Strobe spacing is exactly STEP_DIV clocks while i_enable=1.
  - Each pause stretches that spacing by the number of clocks i_enable was low.
  - The first strobe after reset with i_enable=1 appears STEP_DIV clocks after reset release, provided o_dir_valid is already 1 by then.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, STEP_DIV=10.

1. Reset with i_enable=1 and no keys for 50 clocks → all strobes 0, o_dir=00, o_dir_valid=0.
2. i_key_left held low for 40 clocks → o_dir=10 and o_dir_valid=1 six clocks after the first sampling edge. o_left pulses one clock wide every 10 clocks; o_up/o_down/o_right stay 0.
3. i_key_down low for 3 clocks then high, repeated 5 times → o_dir, o_dir_valid and all strobes unchanged.
4. i_key_up and i_key_right fall on the same edge → o_dir=00. Both are then released → heading holds, o_up keeps pulsing every 10 clocks. A later i_key_right press → o_dir=11 with no timer phase change.
5. With o_left pulsing, i_enable drops for 7 clocks and then returns → no strobes while low. The next strobe arrives 17 clocks after the previous one.
6. i_rst_n asserted low on a clock where o_right=1 → o_right, o_dir and o_dir_valid go to 0 without waiting for a clock edge. After release, no strobe occurs until a new press is accepted.
